// File: rtl/vc_skid_buffer_pkg.sv
// Shared types and constants for the two-entry val/rdy skid buffer.
//   skid_state_t : occupancy state; the encoding doubles as the count output.
//   CountW       : width of the occupancy count.
//   SelEnq/SelSkid : main-register input select values.
package vc_skid_buffer_pkg;

  localparam int unsigned CountW = 2;

  typedef enum logic [CountW-1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_t;

  localparam logic SelEnq  = 1'b0;
  localparam logic SelSkid = 1'b1;

endpackage

// File: rtl/vc_EnReg.sv
// Enable register without reset.
// Ports:
//   clk  : clock
//   en_i : load enable
//   d_i  : next value
//   q_o  : registered value
module vc_EnReg #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic [p_nbits-1:0] d_i,
  output logic [p_nbits-1:0] q_o
);

  logic [p_nbits-1:0] q_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/vc_skid_buffer_ctrl.sv
// Control FSM for the skid buffer: occupancy state, handshake outputs and
// datapath enables.
// Optional: VC_SKID_BUFFER_SQUASH_EN adds squash_i, which flushes all entries.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   enq_val_i          : producer valid
//   deq_rdy_i          : consumer ready
//   squash_i           : flush (only with VC_SKID_BUFFER_SQUASH_EN)
//   enq_rdy_o          : buffer can accept
//   deq_val_o          : head entry valid
//   count_o            : occupancy 0..2
//   main_en_o          : load main register
//   main_sel_o         : main input select (SelEnq / SelSkid)
//   skid_en_o          : load skid register
module vc_skid_buffer_ctrl
  import vc_skid_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_val_i,
  input  logic              deq_rdy_i,
`ifdef VC_SKID_BUFFER_SQUASH_EN
  input  logic              squash_i,
`endif
  output logic              enq_rdy_o,
  output logic              deq_val_o,
  output logic [CountW-1:0] count_o,
  output logic              main_en_o,
  output logic              main_sel_o,
  output logic              skid_en_o
);

  skid_state_t state_q, state_d;
  logic        enq_go, deq_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // enq_rdy depends on reset directly so nothing is accepted while in reset.
  assign enq_rdy_o = (state_q != StFull) && !reset;
  assign deq_val_o = (state_q != StEmpty);
  assign count_o   = state_q;

  assign enq_go = enq_val_i && enq_rdy_o;
  assign deq_go = deq_val_o && deq_rdy_i;

  always_comb begin
    state_d    = state_q;
    main_en_o  = 1'b0;
    main_sel_o = SelEnq;
    skid_en_o  = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (enq_go) begin
          main_en_o = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (enq_go && deq_go) begin
          main_en_o = 1'b1;
        end else if (enq_go) begin
          skid_en_o = 1'b1;
          state_d   = StFull;
        end else if (deq_go) begin
          state_d   = StEmpty;
        end
      end
      StFull: begin
        // enq_go cannot fire here since enq_rdy is low.
        if (deq_go) begin
          main_en_o  = 1'b1;
          main_sel_o = SelSkid;
          state_d    = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
`ifdef VC_SKID_BUFFER_SQUASH_EN
    // A concurrent dequeue still completes; only storage writes are blocked.
    if (squash_i) begin
      state_d   = StEmpty;
      main_en_o = 1'b0;
      skid_en_o = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/vc_skid_buffer.sv
// Two-entry val/rdy skid buffer. Registers deq_val/deq_msg and enq_rdy so the
// deq_rdy -> enq_rdy path is broken while sustaining one message per cycle.
// Optional: VC_SKID_BUFFER_SQUASH_EN adds squash_i to flush all entries.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enq_val_i / enq_rdy_o / enq_msg_i : producer side
//   deq_val_o / deq_rdy_i / deq_msg_o : consumer side (deq_msg_o is the head)
//   count_o    : occupancy 0..2
//   squash_i   : flush (only with VC_SKID_BUFFER_SQUASH_EN)
module vc_skid_buffer
  import vc_skid_buffer_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val_i,
  output logic               enq_rdy_o,
  input  logic [p_nbits-1:0] enq_msg_i,
  output logic               deq_val_o,
  input  logic               deq_rdy_i,
  output logic [p_nbits-1:0] deq_msg_o,
`ifdef VC_SKID_BUFFER_SQUASH_EN
  input  logic               squash_i,
`endif
  output logic [CountW-1:0]  count_o
);

  logic               main_en, main_sel, skid_en;
  logic [p_nbits-1:0] main_d, skid_q;

  vc_skid_buffer_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .enq_val_i  (enq_val_i),
    .deq_rdy_i  (deq_rdy_i),
`ifdef VC_SKID_BUFFER_SQUASH_EN
    .squash_i   (squash_i),
`endif
    .enq_rdy_o  (enq_rdy_o),
    .deq_val_o  (deq_val_o),
    .count_o    (count_o),
    .main_en_o  (main_en),
    .main_sel_o (main_sel),
    .skid_en_o  (skid_en)
  );

  assign main_d = (main_sel == SelSkid) ? skid_q : enq_msg_i;

  vc_EnReg #(.p_nbits(p_nbits)) u_main_reg (
    .clk  (clk),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (deq_msg_o)
  );

  vc_EnReg #(.p_nbits(p_nbits)) u_skid_reg (
    .clk  (clk),
    .en_i (skid_en),
    .d_i  (enq_msg_i),
    .q_o  (skid_q)
  );

endmodule

// File: tb/tb_vc_skid_buffer.sv
// Self-checking bench for vc_skid_buffer: directed checks plus a scoreboard
// that pushes accepted messages and pops them on each dequeue handshake.
module tb_vc_skid_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_val, enq_rdy, deq_val, deq_rdy;
  logic [31:0] enq_msg, deq_msg;
  logic [1:0]  count;
  logic        squash;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  vc_skid_buffer #(.p_nbits(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_val_i (enq_val),
    .enq_rdy_o (enq_rdy),
    .enq_msg_i (enq_msg),
    .deq_val_o (deq_val),
    .deq_rdy_i (deq_rdy),
    .deq_msg_o (deq_msg),
`ifdef VC_SKID_BUFFER_SQUASH_EN
    .squash_i  (squash),
`endif
    .count_o   (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (deq_val && deq_rdy) begin
        if (sb_q.size() == 0) begin
          check_eq("deq_unexpected", 32'd1, 32'd0);
        end else begin
          exp_v = sb_q.pop_front();
          check_eq("sb_deq_msg", deq_msg, exp_v);
        end
      end
      if (squash) begin
        sb_q.delete();
      end else if (enq_val && enq_rdy) begin
        sb_q.push_back(enq_msg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    squash  = 1'b0;
  endtask

  initial begin
    logic [31:0] stream [3];
    stream[0] = 32'h11;
    stream[1] = 32'h22;
    stream[2] = 32'h33;
    idle();
    enq_msg = '0;
    reset   = 1'b1;

    // Reset
    step();
    step();
    check_eq("rst_enq_rdy", {31'd0, enq_rdy}, 32'd0);
    check_eq("rst_deq_val", {31'd0, deq_val}, 32'd0);
    check_eq("rst_count", {30'd0, count}, 32'd0);
    reset = 1'b0;
    step();
    check_eq("post_rst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    check_eq("post_rst_count", {30'd0, count}, 32'd0);

    // Full-throughput stream
    deq_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq_val = 1'b1;
      enq_msg = stream[i];
      step();
      check_eq("stream_deq_val", {31'd0, deq_val}, 32'd1);
      check_eq("stream_head", deq_msg, stream[i]);
      check_eq("stream_count", {30'd0, count}, 32'd1);
      check_eq("stream_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    end
    enq_val = 1'b0;
    step();
    check_eq("stream_drain_count", {30'd0, count}, 32'd0);

    // Backpressure
    deq_rdy = 1'b0;
    enq_val = 1'b1;
    enq_msg = 32'hA0;
    step();
    enq_msg = 32'hA1;
    step();
    check_eq("bp_count_full", {30'd0, count}, 32'd2);
    check_eq("bp_enq_rdy_low", {31'd0, enq_rdy}, 32'd0);
    check_eq("bp_head", deq_msg, 32'hA0);
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    step();
    check_eq("bp_enq_rdy_back", {31'd0, enq_rdy}, 32'd1);
    check_eq("bp_head2", deq_msg, 32'hA1);
    check_eq("bp_count_one", {30'd0, count}, 32'd1);
    step();
    check_eq("bp_count_empty", {30'd0, count}, 32'd0);

    // FULL with enq_val and deq_rdy both high
    deq_rdy = 1'b0;
    enq_val = 1'b1;
    enq_msg = 32'hB0;
    step();
    enq_msg = 32'hB1;
    step();
    enq_msg = 32'hB2;
    deq_rdy = 1'b1;
    step();
    check_eq("full_both_head", deq_msg, 32'hB1);
    check_eq("full_both_count", {30'd0, count}, 32'd1);
    step();
    check_eq("full_both_pending", deq_msg, 32'hB2);
    enq_val = 1'b0;
    step();
    check_eq("full_both_empty", {30'd0, count}, 32'd0);

    // Reset while FULL
    deq_rdy = 1'b0;
    enq_val = 1'b1;
    enq_msg = 32'h51;
    step();
    enq_msg = 32'h52;
    step();
    check_eq("pre_rst_count", {30'd0, count}, 32'd2);
    enq_val = 1'b0;
    reset   = 1'b1;
    step();
    check_eq("mid_rst_count", {30'd0, count}, 32'd0);
    check_eq("mid_rst_deq_val", {31'd0, deq_val}, 32'd0);
    reset   = 1'b0;
    enq_val = 1'b1;
    enq_msg = 32'hC0;
    step();
    check_eq("after_rst_head", deq_msg, 32'hC0);
    check_eq("after_rst_count", {30'd0, count}, 32'd1);
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    step();
    check_eq("after_rst_drain", {30'd0, count}, 32'd0);

`ifdef VC_SKID_BUFFER_SQUASH_EN
    // Squash in FULL with concurrent dequeue and enqueue attempt
    deq_rdy = 1'b0;
    enq_val = 1'b1;
    enq_msg = 32'hD0;
    step();
    enq_msg = 32'hD1;
    step();
    enq_msg = 32'hD2;
    deq_rdy = 1'b1;
    squash  = 1'b1;
    step();
    check_eq("squash_count", {30'd0, count}, 32'd0);
    check_eq("squash_deq_val", {31'd0, deq_val}, 32'd0);
    // Squash in ONE drops a simultaneous enqueue
    squash  = 1'b0;
    deq_rdy = 1'b0;
    enq_msg = 32'hE0;
    step();
    enq_msg = 32'hE1;
    squash  = 1'b1;
    step();
    check_eq("squash_one_count", {30'd0, count}, 32'd0);
    squash  = 1'b0;
`endif

    idle();
    step();
    check_eq("sb_empty_at_end", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
